tp_dis_loader: RTL and testbench

TP_DIS_LOADER -- requirements
Module: tp_dis_loader

---
 rtl/tp_dis_loader_if.sv | 33 +++
 rtl/tp_dis_loader.sv | 186 ++++++++++++++++++
 tb/tb_tp_dis_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tp_dis_loader_if.sv
// ============================================================================
//  Module      : tp_dis_loader_if
//  Description : Host distance-word stream plus the two-point distance write
//                port toward the node array, bundled for tp_dis_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tp_dis_loader_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic                  tp_dis_write;
  logic [2*ADDR_W-1:0]   tp_dis_waddr;
  logic [DATA_W-1:0]     tp_dis_wdata;

  // Host / test side: supplies words, observes the write port.
  modport master (
    output in_valid, in_data,
    input  in_ready, tp_dis_write, tp_dis_waddr, tp_dis_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, tp_dis_write, tp_dis_waddr, tp_dis_wdata
  );
endinterface

`default_nettype wire

// File: rtl/tp_dis_loader.sv
// ============================================================================
//  Module      : tp_dis_loader
//  Description : Loads an N_CITY x N_CITY two-point distance matrix from a
//                host word stream into the node array, one write per cycle.
//                Optional macro TP_DIS_SYM_EN: host sends only the upper
//                triangle; the loader writes zero diagonals itself and
//                mirrors every accepted word to (to,from) on the next cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tp_dis_loader #(
  parameter int N_CITY = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic        abort,
  tp_dis_loader_if.slave   bus,
  output logic             busy,
  output logic             done
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(N_CITY - 1);
  localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef TP_DIS_SYM_EN
  // Sub-step inside LOAD: zero diagonal, host word, mirrored copy.
  typedef enum logic [1:0] {
    PH_DIAG   = 2'd0,
    PH_WORD   = 2'd1,
    PH_MIRROR = 2'd2
  } phase_t;

  phase_t r_phase;
`endif

  state_t              r_state;
  logic [ADDR_W-1:0]   r_from;
  logic [ADDR_W-1:0]   r_to;
  logic                r_last;    // final write already issued
  logic                r_write;
  logic [2*ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy;
  logic                r_done;
  logic                w_ready;

  // A host word is needed only while loading, before the final write, and
  // (symmetric build) only in the word slot, never on diagonal/mirror slots.
`ifdef TP_DIS_SYM_EN
  assign w_ready = (r_state == S_LOAD) && !r_last && (r_phase == PH_WORD);
`else
  assign w_ready = (r_state == S_LOAD) && !r_last;
`endif

  assign bus.in_ready     = w_ready;
  assign bus.tp_dis_write = r_write;
  assign bus.tp_dis_waddr = r_waddr;
  assign bus.tp_dis_wdata = r_wdata;
  assign busy             = r_busy;
  assign done             = r_done;

  // Control FSM, index counters and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_from  <= '0;
      r_to    <= '0;
      r_last  <= 1'b0;
      r_write <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef TP_DIS_SYM_EN
      r_phase <= PH_DIAG;
`endif
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_from  <= '0;
            r_to    <= '0;
            r_last  <= 1'b0;
`ifdef TP_DIS_SYM_EN
            r_phase <= PH_DIAG;
`endif
          end
        end

        S_LOAD: begin
          if (abort) begin
            // Abort wins over any pending word; no write, no done.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end else if (r_last) begin
            // Final write is on the port this cycle; complete next.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_last  <= 1'b0;
          end else begin
`ifdef TP_DIS_SYM_EN
            case (r_phase)
              PH_DIAG: begin
                r_write <= 1'b1;
                r_waddr <= {r_from, r_from};
                r_wdata <= '0;
                if (r_from == c_last) begin
                  r_last <= 1'b1;
                end else begin
                  r_to    <= r_from + c_one;
                  r_phase <= PH_WORD;
                end
              end
              PH_WORD: begin
                if (bus.in_valid) begin
                  r_write <= 1'b1;
                  r_waddr <= {r_from, r_to};
                  r_wdata <= bus.in_data;
                  r_phase <= PH_MIRROR;
                end
              end
              PH_MIRROR: begin
                // Data register still holds the word just written.
                r_write <= 1'b1;
                r_waddr <= {r_to, r_from};
                if (r_to == c_last) begin
                  r_from  <= r_from + c_one;
                  r_phase <= PH_DIAG;
                end else begin
                  r_to    <= r_to + c_one;
                  r_phase <= PH_WORD;
                end
              end
              default: r_phase <= PH_DIAG;
            endcase
`else
            if (bus.in_valid) begin
              r_write <= 1'b1;
              r_waddr <= {r_from, r_to};
              r_wdata <= bus.in_data;
              if (r_to == c_last) begin
                r_to <= '0;
                if (r_from == c_last) begin
                  r_last <= 1'b1;
                end else begin
                  r_from <= r_from + c_one;
                end
              end else begin
                r_to <= r_to + c_one;
              end
            end
`endif
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tp_dis_loader.sv
// ============================================================================
//  Module      : tb_tp_dis_loader
//  Description : Self-checking bench for tp_dis_loader, N_CITY=4, with a
//                write-sequence reference model and a per-cycle compare.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tp_dis_loader;

  localparam int NC    = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int LIMIT = 2000;
`ifdef TP_DIS_SYM_EN
  localparam int NW   = NC * (NC - 1) / 2;
  localparam int BASE = 10;
`else
  localparam int NW   = NC * NC;
  localparam int BASE = 0;
`endif

  typedef struct {
    logic [2*AW-1:0] addr;
    logic [DW-1:0]   data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;

  tp_dis_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  tp_dis_loader #(.N_CITY(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         exp_q[$];
  logic [DW-1:0] words[NW];
  logic        prev_acc;
  logic [DW-1:0] prev_word;
  logic        exp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the full write sequence derived from the host words.
  task automatic build_exp(input int mode);
    wr_t e;
    int  k;
    for (int i = 0; i < NW; i++)
      words[i] = (mode == 0) ? DW'(BASE + i) : DW'($urandom);
    exp_q.delete();
    k = 0;
    for (int f = 0; f < NC; f++) begin
`ifdef TP_DIS_SYM_EN
      e.addr = (2*AW)'(f * NC + f); e.data = '0; exp_q.push_back(e);
      for (int t = f + 1; t < NC; t++) begin
        e.addr = (2*AW)'(f * NC + t); e.data = words[k]; exp_q.push_back(e);
        e.addr = (2*AW)'(t * NC + f); exp_q.push_back(e);
        k++;
      end
`else
      for (int t = 0; t < NC; t++) begin
        e.addr = (2*AW)'(f * NC + t); e.data = words[k]; exp_q.push_back(e);
        k++;
      end
`endif
    end
  endtask

  // Per-cycle compare of the write port, handshake and done against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_acc = 1'b0;
      exp_done = 1'b0;
    end else begin
      check("done", 32'(done), 32'(exp_done));
      exp_done = 1'b0;
      if (prev_acc) begin
        check("accept_to_write", 32'(bus.tp_dis_write), 32'd1);
        check("accept_data", 32'(bus.tp_dis_wdata), 32'(prev_word));
`ifdef TP_DIS_SYM_EN
        check("mirror_ready_low", 32'(bus.in_ready), 32'd0);
`endif
      end
      if (bus.tp_dis_write) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("waddr", 32'(bus.tp_dis_waddr), 32'(e.addr));
          check("wdata", 32'(bus.tp_dis_wdata), 32'(e.data));
          if (exp_q.size() == 0) exp_done = 1'b1;
        end
      end
      if (bus.in_ready) check("ready_only_in_load", 32'(busy), 32'd1);
      prev_acc  = bus.in_valid && bus.in_ready && !abort;
      prev_word = bus.in_data;
    end
  end

  // mode: 0 = valid held, 1 = valid toggling 1,0,1,0, 2 = random stalls.
  task automatic run_load(input int mode, input int abort_at, input int restart_at,
                          input int reset_at);
    int   idx, cyc, dcount, c;
    logic acc;
    build_exp(mode);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; dcount = 0;
    while (idx < NW) begin
      if (cyc >= LIMIT) begin
        check("load_timeout", 32'd1, 32'd0);
        break;
      end
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (cyc % 2 == 0);
        default: bus.in_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.in_data = words[idx];
      start = (cyc == restart_at);
      if (abort_at > 0 && dcount == abort_at) begin
        abort = 1'b1;
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready && !abort;
      @(posedge clk); #1;
      if (abort) begin
        abort = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("abort_busy_low", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        return;
      end
      if (acc) idx++;
      if (bus.tp_dis_write) dcount++;
      if (cyc == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_write", 32'(bus.tp_dis_write), 32'd0);
        check("rst_waddr", 32'(bus.tp_dis_waddr), 32'd0);
        check("rst_wdata", 32'(bus.tp_dis_wdata), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        start = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.in_ready), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        return;
      end
      cyc++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    c = 0;
    while ((busy || done) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 100) check("done_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    check("write_count", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Pin the reference model with hand-derived entries.
    build_exp(0);
    check("model_size", 32'(exp_q.size()), 32'd16);
`ifdef TP_DIS_SYM_EN
    check("model_00", {24'd0, 4'(exp_q[0].addr), exp_q[0].data[3:0]}, 32'h00);
    check("model_01", {24'd0, 4'(exp_q[1].addr), 4'(exp_q[1].data)}, 32'h1A);
    check("model_10", {24'd0, 4'(exp_q[2].addr), 4'(exp_q[2].data)}, 32'h4A);
    check("model_23", {24'd0, 4'(exp_q[13].addr), 4'(exp_q[13].data)}, 32'hBF);
    check("model_32", {24'd0, 4'(exp_q[14].addr), 4'(exp_q[14].data)}, 32'hEF);
`else
    check("model_11", {24'd0, 4'(exp_q[5].addr), 4'(exp_q[5].data)}, 32'h55);
    check("model_33", {24'd0, 4'(exp_q[15].addr), 4'(exp_q[15].data)}, 32'hFF);
`endif
    exp_q.delete();

    repeat (3) @(posedge clk);
    #1;
    check("reset_write", 32'(bus.tp_dis_write), 32'd0);
    check("reset_waddr", 32'(bus.tp_dis_waddr), 32'd0);
    check("reset_wdata", 32'(bus.tp_dis_wdata), 32'd0);
    check("reset_ready", 32'(bus.in_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_load(0, 0, -1, -1);   // sequential words, valid held
    run_load(1, 0, -1, -1);   // valid toggling
    run_load(2, 0, 6, -1);    // random stalls, start re-pulsed while busy

    abort = 1'b1;             // abort outside LOAD has no effect
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    run_load(2, 0, -1, -1);

    run_load(0, 5, -1, -1);   // abort after 5th write
    run_load(0, 0, -1, -1);   // restart from {0,0}
    run_load(2, 0, -1, 7);    // reset mid-load
    run_load(2, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
